// File: rtl/ps2_kbd_tx.sv
// PS/2 keyboard device-side transmitter: queues make/break scan codes and shifts them out as
// 11-bit frames. Define PS2_TX_ERRINJ_EN to add err_inject, which forces a bad parity bit.
module ps2_kbd_tx #(
    parameter int unsigned CLK_DIV    = 50,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [7:0] key_code,
    input  logic       key_release,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       busy,
    output logic       byte_done,
    output logic [7:0] sent_count
`ifdef PS2_TX_ERRINJ_EN
    ,
    input  logic       err_inject
`endif
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned DIV_W = $clog2(2 * CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(FIFO_DEPTH - 2);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StGap} state_e;
    state_e state_q, state_d;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_nx;
    logic [CNT_W-1:0] fifo_cnt_q, push_amt;
    logic [DIV_W-1:0] div_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic [7:0]       sent_q;
    logic             push, pop, period_end, low_phase, err_bit;

`ifdef PS2_TX_ERRINJ_EN
    assign err_bit = err_inject;
`else
    assign err_bit = 1'b0;
`endif

    // Ready needs room for two bytes so a release command is never split.
    assign key_ready  = (fifo_cnt_q <= READY_MAX);
    assign push       = key_valid && key_ready;
    assign pop        = (state_q == StIdle) && (fifo_cnt_q != '0);
    assign push_amt   = push ? (key_release ? CNT_W'(2) : CNT_W'(1)) : '0;
    assign wr_ptr_nx  = wr_ptr_q + PTR_W'(1);
    assign period_end = (div_q == DIV_LAST);
    assign low_phase  = (div_q >= DIV_HALF);
    assign busy       = (state_q != StIdle) || (fifo_cnt_q != '0);
    assign sent_count = sent_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + (key_release ? PTR_W'(2) : PTR_W'(1));
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            fifo_cnt_q <= fifo_cnt_q + push_amt - {{(CNT_W - 1){1'b0}}, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            if (key_release) begin
                fifo_mem[wr_ptr_q]  <= 8'hF0;
                fifo_mem[wr_ptr_nx] <= key_code;
            end else begin
                fifo_mem[wr_ptr_q] <= key_code;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            sent_q   <= '0;
        end else begin
            if (state_q == StIdle) begin
                div_q <= '0;
                bit_q <= '0;
                if (pop) begin
                    shift_q  <= fifo_mem[rd_ptr_q];
                    parity_q <= ~(^fifo_mem[rd_ptr_q]) ^ err_bit;
                end
            end else begin
                div_q <= period_end ? '0 : div_q + DIV_W'(1);
                if (state_q == StData && period_end) begin
                    shift_q <= {1'b0, shift_q[7:1]};
                    bit_q   <= bit_q + 3'd1;
                end
            end
            if (byte_done) begin
                sent_q <= sent_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (pop) state_d = StStart;
            StStart:  if (period_end) state_d = StData;
            StData:   if (period_end && bit_q == 3'd7) state_d = StParity;
            StParity: if (period_end) state_d = StStop;
            StStop:   if (period_end) state_d = StGap;
            StGap:    if (period_end) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        ps2_clk   = 1'b1;
        ps2_data  = 1'b1;
        byte_done = 1'b0;
        unique case (state_q)
            StStart: begin
                ps2_clk  = ~low_phase;
                ps2_data = 1'b0;
            end
            StData: begin
                ps2_clk  = ~low_phase;
                ps2_data = shift_q[0];
            end
            StParity: begin
                ps2_clk  = ~low_phase;
                ps2_data = parity_q;
            end
            StStop: begin
                ps2_clk   = ~low_phase;
                byte_done = period_end;
            end
            default: begin
                ps2_clk  = 1'b1;
                ps2_data = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: scoreboard of expected bytes, frame decoder on ps2_clk falling edges.
module tb_ps2_kbd_tx;
    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned FIFO_DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic       key_release = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       key_ready, ps2_clk, ps2_data, busy, byte_done;
    logic [7:0] sent_count;
    logic       inj_now = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [8:0] exp_q[$];  // {err_inject, byte}

    int          cyc = 0;
    logic [10:0] frame = '0;
    logic [10:0] last_frame = '0;
    int          nbits = 0, n_falls = 0, done_cnt = 0, frames = 0;
    logic        prev_clk = 1'b1;
    logic [7:0]  sc_model = 8'h00;
    int          done_cyc = 0, fall_cyc = 0, gap_meas = 0, len_meas = 0;

    ps2_kbd_tx #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_code   (key_code),
        .key_release(key_release),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .busy       (busy),
        .byte_done  (byte_done),
        .sent_count (sent_count)
`ifdef PS2_TX_ERRINJ_EN
        ,
        .err_inject (inj_now)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic check_frame();
        logic [8:0] e;
        logic       exp_par;
        chk("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            exp_par = (($countones(e[7:0]) % 2) == 0) ^ e[8];
            chk("start_bit", frame[0], 0);
            chk("data_byte", frame[8:1], e[7:0]);
            chk("parity_bit", frame[9], exp_par);
            chk("stop_bit", frame[10], 1);
        end
    endtask

    // Line monitor: decodes frames, tracks byte_done, models sent_count.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            nbits    = 0;
            prev_clk = 1'b1;
            sc_model = 8'h00;
        end else begin
            chk("sent_count", sent_count, sc_model);
            if (prev_clk && !ps2_clk) begin
                n_falls++;
                if (nbits == 0) begin
                    fall_cyc = cyc;
                    gap_meas = cyc - done_cyc;
                end
                frame[nbits] = ps2_data;
                nbits++;
                if (nbits == 11) begin
                    nbits = 0;
                    frames++;
                    last_frame = frame;
                    check_frame();
                end
            end
            if (byte_done) begin
                done_cnt++;
                done_cyc = cyc;
                len_meas = cyc - fall_cyc;
                chk("done_in_stop_low", {ps2_clk, ps2_data}, 2'b01);
                sc_model = sc_model + 8'd1;
            end
            prev_clk = ps2_clk;
        end
    end

    task automatic send_cmd(input logic [7:0] code, input logic rel);
        int n = 0;
        @(negedge clk);
        while (key_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", n < 2000, 1);
        key_valid   = 1'b1;
        key_code    = code;
        key_release = rel;
        @(posedge clk);
        if (rel) exp_q.push_back({inj_now, 8'hF0});
        exp_q.push_back({inj_now, code});
        #1 key_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((busy !== 1'b0 || nbits != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, n < budget, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int snap;
        logic [7:0] codes [4];
        codes[0] = 8'h15; codes[1] = 8'h1D; codes[2] = 8'h24; codes[3] = 8'h2D;

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ps2_clk", ps2_clk, 1);
        chk("rst_ps2_data", ps2_data, 1);
        chk("rst_busy", busy, 0);
        chk("rst_byte_done", byte_done, 0);
        chk("rst_sent_count", sent_count, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", key_ready, 1);

        // Single press 0x1C
        send_cmd(8'h1C, 1'b0);
        chk("busy_after_accept", busy, 1);
        wait_idle("press", 400);
        chk("press_bits", last_frame, {1'b1, 1'b0, 8'h1C, 1'b0});
        chk("press_done_cnt", done_cnt, 1);
        chk("press_count", sent_count, 1);
        chk("frame_len", len_meas, 22 * CLK_DIV - 5);

        // Release 0x1C: F0 then 1C with gap + one idle cycle between frames
        send_cmd(8'h1C, 1'b1);
        wait_idle("release", 600);
        chk("release_done_cnt", done_cnt, 3);
        chk("release_count", sent_count, 3);
        chk("interframe_gap", gap_meas, 3 * CLK_DIV + 2);
        chk("release_frames", frames, 3);

        // Back-to-back releases fill the FIFO
        for (int i = 0; i < 4; i++) send_cmd(codes[i], 1'b1);
        chk("ready_full", key_ready, 0);
        chk("busy_full", busy, 1);
        wait_idle("burst", 1200);
        chk("burst_done_cnt", done_cnt, 11);
        chk("burst_count", sent_count, 11);
        chk("burst_ready", key_ready, 1);
        chk("burst_queue_empty", exp_q.size(), 0);

        // Reset during DATA bit 3
        send_cmd(8'h5A, 1'b0);
        n = 0;
        while (nbits != 5 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("reach_bit3_timeout", n < 400, 1);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_ps2_clk", ps2_clk, 1);
        chk("midrst_ps2_data", ps2_data, 1);
        chk("midrst_count", sent_count, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", key_ready, 1);
        rst = 1'b1;
        exp_q.delete();
        snap = n_falls;
        base = done_cnt;
        repeat (200) @(negedge clk);
        chk("midrst_no_bits", n_falls, snap);
        chk("midrst_no_done", done_cnt, base);
        chk("midrst_idle", busy, 0);

        // 256 presses: sent_count wraps to 0
        base = done_cnt;
        for (int i = 0; i < 256; i++) send_cmd(8'(i), 1'b0);
        n = 0;
        while (done_cnt != base + 255 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_wait_timeout", n < 30000, 1);
        @(negedge clk);
        chk("count_before_wrap", sent_count, 8'hFF);
        wait_idle("wrap", 400);
        chk("wrap_done_cnt", done_cnt - base, 256);
        chk("count_wrapped", sent_count, 8'h00);

`ifdef PS2_TX_ERRINJ_EN
        // Inverted parity on one frame only
        inj_now = 1'b1;
        send_cmd(8'h1C, 1'b0);
        repeat (3) @(negedge clk);
        chk("errinj_parity", ps2_data === 1'b1 || busy === 1'b1, 1);
        inj_now = 1'b0;
        n = frames;
        while (frames == n && busy === 1'b1) @(negedge clk);
        chk("errinj_bits", last_frame, {1'b1, 1'b1, 8'h1C, 1'b0});
        send_cmd(8'h1C, 1'b0);
        wait_idle("errinj", 600);
        chk("errinj_next_bits", last_frame, {1'b1, 1'b0, 8'h1C, 1'b0});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
